// File: rtl/dlx_dp_pkg.sv
// Shared constants and helpers for the DLX datapath arbitration blocks.
package dlx_dp_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Channel-index width; a single bit is kept even for degenerate sizes.
   function automatic int chan_w(input int ch);
      return (clog2(ch) < 1) ? 1 : clog2(ch);
   endfunction

endpackage

// File: rtl/dp_rr_arbiter.sv
// Fixed-priority / round-robin arbiter: one-hot grant plus binary index of the winner.
module dp_rr_arbiter
   import dlx_dp_pkg::*;
#(
   parameter int  CH   = 4,
   parameter int  MODE = ARB_RR,
   localparam int CW   = chan_w(CH)
) (
   input  logic [CH-1:0] req,
   input  logic [CW-1:0] ptr,
   input  logic          en,
   output logic [CH-1:0] gnt,
   output logic [CW-1:0] gnt_idx
);

   int   base;
   int   c;
   logic found;

   // Scan starts at ptr in round-robin mode and at channel 0 in fixed mode.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      c       = 0;
      base    = (MODE == ARB_RR) ? int'(ptr) : 0;
      for (int i = 0; i < CH; i++) begin
         c = (base + i) % CH;
         if (!found && req[c]) begin
            found   = 1'b1;
            gnt_idx = CW'(c);
            if (en) gnt[c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dp_arbmux.sv
// Arbitrated CH-channel datapath mux with a single registered output stage.
// Optional `DP_ARBMUX_XPROP_EN: X/Z on IN_VALID (or OUT_READY while full) poisons the output register.
module dp_arbmux
   import dlx_dp_pkg::*;
#(
   parameter int  N    = 32,
   parameter int  CH   = 4,
   parameter int  MODE = ARB_RR,
   localparam int CW   = chan_w(CH)
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic [CH*N-1:0] IN_DATA,
   input  logic [CH-1:0]   IN_VALID,
   output logic [CH-1:0]   IN_READY,
   output logic [N-1:0]    OUT_DATA,
   output logic [CW-1:0]   OUT_CHAN,
   output logic            OUT_VALID,
   input  logic            OUT_READY
);

   logic [CH-1:0] in_valid_s;
   logic          out_ready_s;
   logic          load;
   logic          arb_en;
   logic          xfer;
   logic [CH-1:0] gnt;
   logic [CW-1:0] gnt_idx;
   logic [N-1:0]  sel_data;

   logic          out_valid_d, out_valid_q;
   logic [N-1:0]  out_data_d,  out_data_q;
   logic [CW-1:0] out_chan_d,  out_chan_q;
   logic [CW-1:0] ptr_d,       ptr_q;

`ifdef DP_ARBMUX_XPROP_EN
   assign in_valid_s  = IN_VALID;
   assign out_ready_s = OUT_READY;
`else
   // Unknown handshake bits resolve to 0 so the select stays clean.
   always_comb begin
      in_valid_s = '0;
      for (int i = 0; i < CH; i++) in_valid_s[i] = (IN_VALID[i] === 1'b1);
   end
   assign out_ready_s = (OUT_READY === 1'b1);
`endif

   assign load   = ~out_valid_q | out_ready_s;
   assign arb_en = load & RESET_N;

   dp_rr_arbiter #(
      .CH   (CH),
      .MODE (MODE)
   ) u_arb (
      .req     (in_valid_s),
      .ptr     (ptr_q),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign IN_READY = gnt;
   assign xfer     = |gnt;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < CH; i++) sel_data = sel_data | (IN_DATA[i*N +: N] & {N{gnt[i]}});
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_chan_d  = gnt_idx;
         if (MODE == ARB_RR) ptr_d = (gnt_idx == CW'(CH - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (out_ready_s) begin
         out_valid_d = 1'b0;
      end
`ifdef DP_ARBMUX_XPROP_EN
      if ($isunknown(IN_VALID) || (out_valid_q && $isunknown(OUT_READY))) begin
         out_data_d  = 'x;
         out_valid_d = 1'bx;
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         ptr_q       <= ptr_d;
      end
   end

   assign OUT_VALID = out_valid_q;
   assign OUT_DATA  = out_data_q;
   assign OUT_CHAN  = out_chan_q;

endmodule

// File: tb/tb_dp_arbmux.sv
// Bench for dp_arbmux: fixed-priority and round-robin instances share stimulus, checked against a behavioural model.
module tb_dp_arbmux;

   localparam int N  = 32;
   localparam int CH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [CH*N-1:0] in_data;
   logic [CH-1:0]   in_valid;
   logic            out_ready;

   logic [CH-1:0] rdy   [2];
   logic [N-1:0]  odata [2];
   logic [1:0]    ochan [2];
   logic          ovld  [2];

   int errors = 0;
   int checks = 0;

   // Model state per instance: 0 = fixed priority, 1 = round robin.
   logic         m_vld  [2];
   logic [N-1:0] m_data [2];
   int           m_chan [2];
   int           m_ptr  [2];

   dp_arbmux #(.N(N), .CH(CH), .MODE(0)) u_fixed (
      .CLK(clk), .RESET_N(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(rdy[0]),
      .OUT_DATA(odata[0]), .OUT_CHAN(ochan[0]), .OUT_VALID(ovld[0]), .OUT_READY(out_ready)
   );

   dp_arbmux #(.N(N), .CH(CH), .MODE(1)) u_rr (
      .CLK(clk), .RESET_N(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(rdy[1]),
      .OUT_DATA(odata[1]), .OUT_CHAN(ochan[1]), .OUT_VALID(ovld[1]), .OUT_READY(out_ready)
   );

   function automatic int pick(int m);
      int c;
      for (int k = 0; k < CH; k++) begin
         c = (m == 1) ? (m_ptr[m] + k) % CH : k;
         if (in_valid[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [CH-1:0] exp_rdy(int m);
      int g;
      g = pick(m);
      if (!rst_n || g < 0 || (m_vld[m] && !out_ready)) return '0;
      return CH'(1) << g;
   endfunction

   task automatic tick();
      logic [CH-1:0] r [2];
      int            g [2];
      for (int m = 0; m < 2; m++) begin
         r[m] = exp_rdy(m);
         g[m] = pick(m);
      end
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         if (!rst_n) begin
            m_vld[m] = 1'b0; m_data[m] = '0; m_chan[m] = 0; m_ptr[m] = 0;
         end else if (r[m] != 0) begin
            m_vld[m]  = 1'b1;
            m_data[m] = in_data[g[m]*N +: N];
            m_chan[m] = g[m];
            if (m == 1) m_ptr[m] = (g[m] + 1) % CH;
         end else if (out_ready) begin
            m_vld[m] = 1'b0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = {$urandom, $urandom, $urandom, $urandom};
         #1;
         for (int m = 0; m < 2; m++) begin
            checks++;
            if (rdy[m] !== 4'h0) begin errors++; $display("FAIL reset_ready[%0d] got %b want 0000", m, rdy[m]); end
         end
         tick();
         for (int m = 0; m < 2; m++) begin
            checks++;
            if (ovld[m] !== 1'b0 || odata[m] !== 32'h0 || ochan[m] !== 2'd0) begin
               errors++;
               $display("FAIL reset_out[%0d] got vld=%b data=%h chan=%0d want 0/0/0", m, ovld[m], odata[m], ochan[m]);
            end
         end
      end
   endtask

   task automatic test_rr_sequence();
      int seq [5] = '{0, 1, 2, 3, 0};
      rst_n = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
      for (int c = 0; c < CH; c++) in_data[c*N +: N] = 32'hA0 + c;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (rdy[1] !== (4'b1 << seq[i])) begin errors++; $display("FAIL rr_ready step %0d got %b want %b", i, rdy[1], 4'b1 << seq[i]); end
         tick();
         checks++;
         if (ochan[1] !== 2'(seq[i]) || ovld[1] !== 1'b1 || odata[1] !== 32'hA0 + 32'(seq[i])) begin
            errors++;
            $display("FAIL rr_out step %0d got chan=%0d vld=%b data=%h want chan=%0d vld=1 data=%h",
                     i, ochan[1], ovld[1], odata[1], seq[i], 32'hA0 + 32'(seq[i]));
         end
         checks++;
         if (ochan[0] !== 2'd0) begin errors++; $display("FAIL fixed_with_all step %0d got chan=%0d want 0", i, ochan[0]); end
      end
   endtask

   task automatic test_fixed_prio();
      in_valid = 4'b1010; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = {$urandom, $urandom, $urandom, $urandom};
         #1;
         checks++;
         if (rdy[0] !== 4'b0010) begin errors++; $display("FAIL fixed_ready cyc %0d got %b want 0010", i, rdy[0]); end
         tick();
         checks++;
         if (ochan[0] !== 2'd1 || odata[0] !== in_data[N +: N]) begin
            errors++;
            $display("FAIL fixed_out cyc %0d got chan=%0d data=%h want chan=1 data=%h", i, ochan[0], odata[0], in_data[N +: N]);
         end
      end
   endtask

   task automatic test_backpressure();
      in_valid = 4'b0100; out_ready = 1'b1;
      in_data = {$urandom, 32'hDEAD_BEEF, $urandom, $urandom};
      #1; tick();
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (odata[m] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_load[%0d] got %h want deadbeef", m, odata[m]); end
      end
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 4'($urandom_range(1, 15));
         in_data  = {$urandom, $urandom, $urandom, $urandom};
         #1;
         for (int m = 0; m < 2; m++) begin
            checks++;
            if (rdy[m] !== 4'h0) begin errors++; $display("FAIL bp_ready[%0d] cyc %0d got %b want 0000", m, i, rdy[m]); end
         end
         tick();
         for (int m = 0; m < 2; m++) begin
            checks++;
            if (odata[m] !== 32'hDEAD_BEEF || ovld[m] !== 1'b1 || ochan[m] !== 2'd2) begin
               errors++;
               $display("FAIL bp_hold[%0d] cyc %0d got data=%h vld=%b chan=%0d want deadbeef/1/2", m, i, odata[m], ovld[m], ochan[m]);
            end
         end
      end
      out_ready = 1'b1; in_valid = 4'b0001;
      in_data = {$urandom, $urandom, $urandom, 32'h1234_5678};
      #1;
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (rdy[m] !== 4'b0001) begin errors++; $display("FAIL bp_release_ready[%0d] got %b want 0001", m, rdy[m]); end
      end
      tick();
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (odata[m] !== 32'h1234_5678 || ochan[m] !== 2'd0 || ovld[m] !== 1'b1) begin
            errors++;
            $display("FAIL bp_next[%0d] got data=%h chan=%0d vld=%b want 12345678/0/1", m, odata[m], ochan[m], ovld[m]);
         end
      end
      in_valid = 4'h0;
      #1; tick();
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (ovld[m] !== 1'b0 || odata[m] !== 32'h1234_5678 || ochan[m] !== 2'd0) begin
            errors++;
            $display("FAIL drain[%0d] got vld=%b data=%h chan=%0d want 0/12345678/0", m, ovld[m], odata[m], ochan[m]);
         end
      end
   endtask

   task automatic test_wrap();
      out_ready = 1'b1;
      in_valid = 4'b0100;
      #1; tick();
      in_valid = 4'b0001;
      #1;
      checks++;
      if (rdy[1] !== 4'b0001) begin errors++; $display("FAIL wrap_ready0 got %b want 0001", rdy[1]); end
      tick();
      checks++;
      if (ochan[1] !== 2'd0) begin errors++; $display("FAIL wrap_chan0 got %0d want 0", ochan[1]); end
      in_valid = 4'b1001;
      #1;
      checks++;
      if (rdy[1] !== 4'b1000 || rdy[0] !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_ready3 got rr=%b fixed=%b want 1000/0001", rdy[1], rdy[0]);
      end
      tick();
      checks++;
      if (ochan[1] !== 2'd3) begin errors++; $display("FAIL wrap_chan3 got %0d want 3", ochan[1]); end
   endtask

   task automatic test_midflight_reset();
      out_ready = 1'b1; in_valid = 4'b0010;
      #1; tick();
      out_ready = 1'b0; in_valid = 4'hF; rst_n = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (rdy[m] !== 4'h0) begin errors++; $display("FAIL mid_reset_ready[%0d] got %b want 0000", m, rdy[m]); end
      end
      tick();
      for (int m = 0; m < 2; m++) begin
         checks++;
         if (ovld[m] !== 1'b0 || odata[m] !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_out[%0d] got vld=%b data=%h want 0/0", m, ovld[m], odata[m]);
         end
      end
      rst_n = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (rdy[1] !== 4'b0001) begin errors++; $display("FAIL mid_reset_ptr got %b want 0001", rdy[1]); end
      tick();
      checks++;
      if (ochan[1] !== 2'd0) begin errors++; $display("FAIL mid_reset_chan got %0d want 0", ochan[1]); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst_n     = ($urandom_range(0, 49) != 0);
         in_valid  = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         #1;
         for (int m = 0; m < 2; m++) begin
            checks++;
            if (rdy[m] !== exp_rdy(m)) begin
               errors++; $display("FAIL rand_ready[%0d] cyc %0d got %b want %b", m, i, rdy[m], exp_rdy(m));
            end
         end
         tick();
         for (int m = 0; m < 2; m++) begin
            checks++;
            if (ovld[m] !== m_vld[m] || odata[m] !== m_data[m] || ochan[m] !== 2'(m_chan[m])) begin
               errors++;
               $display("FAIL rand_out[%0d] cyc %0d got vld=%b data=%h chan=%0d want vld=%b data=%h chan=%0d",
                        m, i, ovld[m], odata[m], ochan[m], m_vld[m], m_data[m], m_chan[m]);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = '0; out_ready = 1'b0; in_data = '0;
      for (int m = 0; m < 2; m++) begin
         m_vld[m] = 1'b0; m_data[m] = '0; m_chan[m] = 0; m_ptr[m] = 0;
      end
      test_reset();
      test_rr_sequence();
      test_fixed_prio();
      test_backpressure();
      test_wrap();
      test_midflight_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
